dmem_responder: RTL

Data-memory responder at the far end of the datapath's load/store port. It accepts one word request at a time from the processor (address = `aluout`, store data = `writedata`) and inserts a programmable number of wait states. It then commits the store or returns the load word (`readdata`) with a one-cycle `ready` pulse. It replaces the zero-latency data-memory model so that the stalling control path can be exercised.

---
 rtl/dmem_if.sv | 27 ++
 rtl/dmem_responder.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/dmem_if.sv
`default_nettype none
// ============================================================================
// Module   : dmem_if
// Purpose  : Load/store handshake bundle between datapath and data memory.
//            Macro DMEM_BYTE_STROBE_EN adds the byte-enable field.
// Revision : 1.0
// ============================================================================
interface dmem_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        err;
  logic        busy;
`ifdef DMEM_BYTE_STROBE_EN
  logic [3:0]  be;

  modport master (output req, we, addr, wdata, be, input rdata, ready, err, busy);
  modport slave  (input req, we, addr, wdata, be, output rdata, ready, err, busy);
`else
  modport master (output req, we, addr, wdata, input rdata, ready, err, busy);
  modport slave  (input req, we, addr, wdata, output rdata, ready, err, busy);
`endif
endinterface
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : dmem_responder
// Purpose  : Word data memory with programmable wait states and fault check.
//            Macro DMEM_BYTE_STROBE_EN enables per-byte store strobes.
// Revision : 1.0
// ============================================================================
module dmem_responder #(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h10010000,
  parameter int          WAIT_CYCLES = 2
) (
  input  wire logic clk,
  input  wire logic reset,
  dmem_if.slave     bus
);

  localparam int          c_IDXW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [32:0] c_SPAN = 33'(4 * DEPTH_WORDS);
  localparam logic [3:0]  c_WAIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_mem [DEPTH_WORDS];

  logic              w_sel_in;
  logic              w_we;
  logic [31:0]       w_addr;
  logic [31:0]       w_wdata;
  logic [3:0]        w_be;
  logic [31:0]       w_off;
  logic              w_fault;
  logic [c_IDXW-1:0] w_idx;
  logic [31:0]       w_old;
  logic [31:0]       w_merged;
  logic              w_enter_resp;

  // In IDLE with zero wait states the access resolves on the acceptance edge,
  // so the live inputs are used instead of the not-yet-captured registers.
  assign w_sel_in = (r_state == S_IDLE);
  assign w_we     = w_sel_in ? bus.we    : r_we;
  assign w_addr   = w_sel_in ? bus.addr  : r_addr;
  assign w_wdata  = w_sel_in ? bus.wdata : r_wdata;

`ifdef DMEM_BYTE_STROBE_EN
  logic [3:0] r_be;
  assign w_be = w_sel_in ? bus.be : r_be;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_be <= 4'd0;
    end else if (r_state == S_IDLE && bus.req) begin
      r_be <= bus.be;
    end
  end
`else
  assign w_be = 4'hF;
`endif

  assign w_off   = w_addr - BASE_ADDR;
  assign w_fault = (w_addr[1:0] != 2'b00) || (w_addr < BASE_ADDR) ||
                   ({1'b0, w_off} >= c_SPAN);
  assign w_idx   = w_off[c_IDXW+1:2];
  assign w_old   = r_mem[w_idx];

  always_comb begin
    w_merged = w_old;
    for (int i = 0; i < 4; i++) begin
      if (w_be[i]) begin
        w_merged[8*i +: 8] = w_wdata[8*i +: 8];
      end
    end
  end

  assign w_enter_resp = (r_state == S_IDLE && bus.req && c_WAIT == 4'd0) ||
                        (r_state == S_WAIT && r_cnt == 4'd1);

  // Array has no reset; the reset term keeps a held request from writing.
  always_ff @(posedge clk) begin
    if (reset && w_enter_resp && w_we && !w_fault) begin
      r_mem[w_idx] <= w_merged;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= 4'd0;
      r_we      <= 1'b0;
      r_addr    <= 32'd0;
      r_wdata   <= 32'd0;
      bus.ready <= 1'b0;
      bus.err   <= 1'b0;
      bus.busy  <= 1'b0;
      bus.rdata <= 32'd0;
    end else begin
      bus.ready <= 1'b0;
      bus.err   <= 1'b0;
      bus.rdata <= 32'd0;
      case (r_state)
        S_IDLE: begin
          if (bus.req) begin
            r_we     <= bus.we;
            r_addr   <= bus.addr;
            r_wdata  <= bus.wdata;
            r_cnt    <= c_WAIT;
            bus.busy <= 1'b1;
            r_state  <= (c_WAIT == 4'd0) ? S_RESP : S_WAIT;
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            r_state <= S_RESP;
          end
        end
        S_RESP: begin
          bus.busy <= 1'b0;
          r_state  <= S_IDLE;
        end
        default: begin
          bus.busy <= 1'b0;
          r_state  <= S_IDLE;
        end
      endcase
      if (w_enter_resp) begin
        bus.ready <= 1'b1;
        bus.err   <= w_fault;
        bus.rdata <= w_fault ? 32'd0 : (w_we ? w_merged : w_old);
      end
    end
  end

endmodule
`default_nettype wire
